rb_loader: RTL and testbench
============================

# rb_loader

Serial configuration front end for the neuron grid register banks. Deserialises a framed bit stream into 2-byte write packets (header + payload), decodes the target neuron and register, and drives the shared `data_in`/`select` bus, a one-hot per-neuron `en` vector and a single-cycle `trig` strobe. It sits directly upstream of the per-neuron register banks, one instance per grid.

## Interface
- `N_NEURONS`, 4: number of register banks addressed; legal range is 1..64.
- `IDX_W`, 6: header neuron-index field width. Fixed; not overridable.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame`  in  1  packet framing; high for the whole packet.
- `ser_valid`  in  1  qualifies `ser_in` for one cycle.
- `ser_in`  in  1  serial data bit, MSB first.
- `data_in`  out  8  payload byte to the banks.
- `select`  out  2  register select: 0 = win, 1 = bias, 2 = sign.
- `en`  out  N_NEURONS  one-hot neuron enable.
- `trig`  out  1  one-cycle write strobe.
- `busy`  out  1  high while a packet is in progress.
- `err`  out  1  sticky error flag.

## Operation
- Packet format: header byte `{idx[5:0], sel[1:0]}`, then payload byte. Bits are shifted in MSB first, only on cycles with `ser_valid && frame`.
- FSM has four states: IDLE, HDR, DAT, WR.
  - IDLE → HDR on the first cycle with `frame` high. Clear the bit counter.
  - HDR: after 8 qualified bits, latch idx/sel and go to DAT.
  - DAT: after 8 qualified bits, go to WR.
  - WR: lasts one cycle, then returns to IDLE. Then wait for `frame` low before accepting a new packet. Extra bits inside the same frame are ignored.
- Decode runs in WR:
  - If `idx < N_NEURONS` and `sel != 3`: update `data_in`, `select` and `en` (one-hot of idx) and pulse `trig`.
  - Otherwise: no `trig`, outputs unchanged, `err` set.
- `data_in`, `select` and `en` are registered. They hold their values until the next valid write.
- `frame` dropping in HDR or DAT: abort to IDLE, no write, `err` unchanged. A partial packet is silently discarded.
- `err` is cleared only by reset.
- `busy` is high in HDR, DAT and WR.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary.

## Timing
- Reset values: `data_in` = 0, `select` = 0, `en` = 0, `trig` = 0, `busy` = 0, `err` = 0. FSM returns to IDLE.
- Latency: the edge sampling the 16th qualified bit enters WR. `trig`, `data_in`, `select` and `en` are valid in the cycle after that edge. The bank captures on the following rising edge.
- `trig` is high for exactly one cycle per valid packet.
- `ser_valid` may be asserted every cycle (full rate) or sparsely. Gaps of any length are allowed within a frame.
- Reset asserted mid-packet: immediate return to reset values. No `trig` is generated.
- `frame` dropping in the same cycle as the 16th qualified bit: the packet completes normally, because the bit is qualified by `frame` high on that edge.

## Configuration
- `RB_LOADER_PARITY_EN` defined:
  - Each byte is followed by a 9th qualified bit carrying even parity over the 8 data bits.
  - A header or payload mismatch sets `err`. The packet is discarded with no `trig`.
  - A packet is 18 qualified bits.
- Not defined: there are no parity bits and a packet is 16 bits.
- The bit counter widens to 4 bits when the macro is defined.

## Structure
- The shared neuron-grid package holds:
  - register-select constants `SEL_WIN` = 0, `SEL_BIAS` = 1, `SEL_SIGN` = 2;
  - the FSM state enum;
  - `IDX_W`.
- One natural sub-module, `ser_shift8`: shift register plus bit counter (plus parity check when enabled). It outputs `byte_done` and `byte_q`.

## Test plan
- Reset, then packet `0x05` (idx 1, sel 1) + `0xA7`, `N_NEURONS` = 4, full-rate `ser_valid` → exactly one `trig`; `en` = 4'b0010, `select` = 1, `data_in` = 0xA7; `err` = 0.
- Packet `0x12` (idx 4, sel 2) with `N_NEURONS` = 4 → no `trig`, `err` = 1, previous `data_in`/`select`/`en` retained.
- Header `0x03` (sel 3) → no `trig`, `err` = 1.
- `frame` dropped after 11 bits, then a valid `0x00` + `0x01` packet → one `trig` only; `en` = 4'b0001, `select` = 0, `data_in` = 0x01; `err` = 0.
- `rst_n` pulsed low during DAT → all outputs 0 immediately; no `trig` after release until a full new packet arrives.
- With `RB_LOADER_PARITY_EN`: payload `0xA7` sent with parity bit 0 (wrong; correct is 1) → no `trig`, `err` = 1. Same packet with the correct parity → `trig`, `data_in` = 0xA7.

Source files
------------

// File: rtl/rb_loader_pkg.sv
// Shared neuron-grid definitions for the register-bank loader.
// RB_LOADER_PARITY_EN selects the 9-bit-per-byte (even parity) framing.
package rb_loader_pkg;

    localparam int IDX_W = 6;

    localparam logic [1:0] SEL_WIN  = 2'd0;
    localparam logic [1:0] SEL_BIAS = 2'd1;
    localparam logic [1:0] SEL_SIGN = 2'd2;
    localparam logic [1:0] SEL_RSVD = 2'd3;

`ifdef RB_LOADER_PARITY_EN
    localparam int CNT_W         = 4;
    localparam int BITS_PER_BYTE = 9;
`else
    localparam int CNT_W         = 3;
    localparam int BITS_PER_BYTE = 8;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DAT  = 2'd2,
        ST_WR   = 2'd3
    } state_t;

endpackage

// File: rtl/rb_loader_ser_shift8.sv
// Serial-to-byte shifter with wrapping bit counter for rb_loader.
// RB_LOADER_PARITY_EN adds a trailing even-parity bit per byte.
module ser_shift8
    import rb_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       shift,
    input  logic       bit_in,
    output logic       byte_done,
    output logic [7:0] byte_q,
    output logic       par_err
);

    localparam int                SR_W = BITS_PER_BYTE - 1;
    localparam logic [CNT_W-1:0]  LAST = CNT_W'(BITS_PER_BYTE - 1);

    logic [SR_W-1:0]  sr;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (shift) begin
            sr  <= {sr[SR_W-2:0], bit_in};
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // byte_done fires on the edge that samples the last bit of the byte,
    // so byte_q includes the bit currently on bit_in where applicable.
    assign byte_done = shift && (cnt == LAST);

`ifdef RB_LOADER_PARITY_EN
    assign byte_q  = sr;
    assign par_err = byte_done && (bit_in != (^sr));
`else
    assign byte_q  = {sr, bit_in};
    assign par_err = 1'b0;
`endif

endmodule

// File: rtl/rb_loader.sv
// Serial configuration front end: framed bit stream -> neuron register bank writes.
// Optional RB_LOADER_PARITY_EN: per-byte even parity, mismatches set err.
module rb_loader
    import rb_loader_pkg::*;
#(
    parameter int N_NEURONS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame,
    input  logic                 ser_valid,
    input  logic                 ser_in,
    output logic [7:0]           data_in,
    output logic [1:0]           select,
    output logic [N_NEURONS-1:0] en,
    output logic                 trig,
    output logic                 busy,
    output logic                 err
);

    state_t           state;
    logic             armed;
    logic [IDX_W-1:0] hdr_idx;
    logic [1:0]       hdr_sel;
    logic             hdr_perr;

    logic             shift;
    logic             clr;
    logic             byte_done;
    logic [7:0]       byte_q;
    logic             par_err;
    logic             pkt_ok;

    assign shift = ser_valid && frame && ((state == ST_HDR) || (state == ST_DAT));
    assign clr   = (state == ST_IDLE);

    ser_shift8 u_shift (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .shift     (shift),
        .bit_in    (ser_in),
        .byte_done (byte_done),
        .byte_q    (byte_q),
        .par_err   (par_err)
    );

    function automatic logic [N_NEURONS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_NEURONS-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    assign pkt_ok = (int'(hdr_idx) < N_NEURONS) && (hdr_sel != SEL_RSVD) &&
                    !hdr_perr && !par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            armed    <= 1'b1;
            hdr_idx  <= '0;
            hdr_sel  <= SEL_WIN;
            hdr_perr <= 1'b0;
            data_in  <= '0;
            select   <= SEL_WIN;
            en       <= '0;
            trig     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            trig <= 1'b0;
            // A new packet needs a low frame first, so trailing bits of a
            // completed frame can never start a second packet.
            if (!frame) armed <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (frame && armed) begin
                        state <= ST_HDR;
                        busy  <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (byte_done) begin
                        hdr_idx  <= byte_q[7:2];
                        hdr_sel  <= byte_q[1:0];
                        hdr_perr <= par_err;
                        state    <= ST_DAT;
                    end else if (!frame) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_DAT: begin
                    if (byte_done) begin
                        state <= ST_WR;
                        armed <= 1'b0;
                        // Decode is registered on the WR entry edge so the
                        // outputs and trig are valid throughout WR.
                        if (pkt_ok) begin
                            data_in <= byte_q;
                            select  <= hdr_sel;
                            en      <= onehot(hdr_idx);
                            trig    <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (!frame) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_WR: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rb_loader.sv
// Scoreboard bench for rb_loader: directed packets, monitor checks every trig.
module tb_rb_loader;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         frame;
    logic         ser_valid;
    logic         ser_in;
    logic [7:0]   data_in;
    logic [1:0]   select;
    logic [N-1:0] en;
    logic         trig;
    logic         busy;
    logic         err;

    typedef struct {
        logic [7:0]   data;
        logic [1:0]   sel;
        logic [N-1:0] en;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    rb_loader #(.N_NEURONS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame     (frame),
        .ser_valid (ser_valid),
        .ser_in    (ser_in),
        .data_in   (data_in),
        .select    (select),
        .en        (en),
        .trig      (trig),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every trig must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && trig === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_trig: got trig=1 data_in=0x%0h expected no trig", data_in);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_data_in", 32'(data_in), 32'(e.data));
                chk("wr_select",  32'(select),  32'(e.sel));
                chk("wr_en",      32'(en),      32'(e.en));
            end
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic [1:0] s, input logic [N-1:0] e);
        exp_t x;
        x.data = d;
        x.sel  = s;
        x.en   = e;
        exp_q.push_back(x);
    endtask

    // Sends header+payload MSB first; nbits<0 sends the whole packet.
    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pay, input int nbits,
                            input bit sparse, input bit bad_par, input bit hold);
        logic bits[$];
        int   n;
        for (int i = 7; i >= 0; i--) bits.push_back(hdr[i]);
`ifdef RB_LOADER_PARITY_EN
        bits.push_back(^hdr);
`endif
        for (int i = 7; i >= 0; i--) bits.push_back(pay[i]);
`ifdef RB_LOADER_PARITY_EN
        bits.push_back((^pay) ^ bad_par);
`endif
        n = (nbits < 0) ? bits.size() : nbits;
        frame = 1'b1;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            ser_valid = 1'b1;
            ser_in    = bits[i];
            @(negedge clk);
            if (i == 3) chk("busy_mid_packet", 32'(busy), 32'd1);
            if (sparse) begin
                ser_valid = 1'b0;
                ser_in    = ~bits[i];
                repeat (2) @(negedge clk);
            end
        end
        ser_valid = 1'b0;
        if (!hold) begin
            frame = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        frame     = 1'b0;
        ser_valid = 1'b0;
        ser_in    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data_in", 32'(data_in), 32'd0);
        chk("rst_select",  32'(select),  32'd0);
        chk("rst_en",      32'(en),      32'd0);
        chk("rst_trig",    32'(trig),    32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_err",     32'(err),     32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // idx 1, sel 1, full rate
        push_exp(8'hA7, 2'd1, 4'b0010);
        send_pkt(8'h05, 8'hA7, -1, 1'b0, 1'b0, 1'b0);
        chk("t1_err",  32'(err),  32'd0);
        chk("t1_busy", 32'(busy), 32'd0);

        // frame dropped after 11 bits, then a valid packet
        send_pkt(8'h00, 8'h01, 11, 1'b0, 1'b0, 1'b0);
        chk("abort_err", 32'(err), 32'd0);
        push_exp(8'h01, 2'd0, 4'b0001);
        send_pkt(8'h00, 8'h01, -1, 1'b0, 1'b0, 1'b0);
        chk("t4_err", 32'(err), 32'd0);

        // idx 4 out of range: error, outputs retained
        send_pkt(8'h12, 8'hA7, -1, 1'b0, 1'b0, 1'b0);
        chk("idx_err",      32'(err),     32'd1);
        chk("idx_data_ret", 32'(data_in), 32'h01);
        chk("idx_sel_ret",  32'(select),  32'd0);
        chk("idx_en_ret",   32'(en),      32'b0001);

        // reserved select
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_err", 32'(err), 32'd0);
        send_pkt(8'h03, 8'h55, -1, 1'b0, 1'b0, 1'b0);
        chk("sel3_err", 32'(err), 32'd1);
        chk("sel3_en",  32'(en),  32'd0);

        // reset asserted during DAT
        push_exp(8'hC3, 2'd1, 4'b0100);
        send_pkt(8'h09, 8'hC3, -1, 1'b0, 1'b0, 1'b0);
        send_pkt(8'h0E, 8'h5C, 11, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data_in", 32'(data_in), 32'd0);
        chk("mid_rst_en",      32'(en),      32'd0);
        chk("mid_rst_select",  32'(select),  32'd0);
        chk("mid_rst_busy",    32'(busy),    32'd0);
        chk("mid_rst_err",     32'(err),     32'd0);
        @(negedge clk);
        frame = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        push_exp(8'h5C, 2'd2, 4'b1000);
        send_pkt(8'h0E, 8'h5C, -1, 1'b1, 1'b0, 1'b0);
        chk("sparse_err", 32'(err), 32'd0);

`ifdef RB_LOADER_PARITY_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_pkt(8'h05, 8'hA7, -1, 1'b0, 1'b1, 1'b0);
        chk("par_bad_err", 32'(err), 32'd1);
        push_exp(8'hA7, 2'd1, 4'b0010);
        send_pkt(8'h05, 8'hA7, -1, 1'b0, 1'b0, 1'b0);
        chk("par_good_data", 32'(data_in), 32'hA7);
`endif

        repeat (5) @(negedge clk);
        chk("pending_trigs", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test expected finish before 200000");
        $fatal(1);
    end

endmodule
